// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin owner of the register file write port
// Runs a 32-entry clear sweep after reset, then grants one requester write per cycle.
module regfile_write_arbiter #(
  parameter int NREQ        = 3,
  parameter bit INIT_EN     = 1'b1,
  parameter bit ZERO_FILTER = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*5-1:0]    req_reg,
  input  logic [NREQ*32-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 RegWrite,
  output logic [4:0]           WriteReg,
  output logic [31:0]          WriteData,
  output logic                 init_busy
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            regwrite_q, regwrite_d;
  logic [4:0]      writereg_q, writereg_d;
  logic [31:0]     writedata_q, writedata_d;

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   gnt_idx;
  logic            found;
  logic [4:0]      sel_reg;
  logic [31:0]     sel_data;
  int              idx;

  // Rotating priority search starting at rr_ptr; only live in RUN.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    if (state_q == ST_RUN) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(rr_ptr_q) + k) % NREQ;
        if (!found && req_valid[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          gnt_idx    = PW'(idx);
        end
      end
    end
  end

  assign sel_reg  = req_reg[int'(gnt_idx)*5 +: 5];
  assign sel_data = req_data[int'(gnt_idx)*32 +: 32];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    regwrite_d  = 1'b0;
    writereg_d  = writereg_q;
    writedata_d = writedata_q;
    if (state_q == ST_INIT) begin
      regwrite_d  = 1'b1;
      writereg_d  = cnt_q;
      writedata_d = '0;
      cnt_d       = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        state_d = ST_RUN;
      end
    end else if (found) begin
      writereg_d  = sel_reg;
      writedata_d = sel_data;
      // A filtered register-0 write is still a completed transfer.
      regwrite_d  = !(ZERO_FILTER && (sel_reg == 5'd0));
      rr_ptr_d    = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= INIT_EN ? ST_INIT : ST_RUN;
      cnt_q       <= '0;
      rr_ptr_q    <= '0;
      regwrite_q  <= 1'b0;
      writereg_q  <= '0;
      writedata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      regwrite_q  <= regwrite_d;
      writereg_q  <= writereg_d;
      writedata_q <= writedata_d;
    end
  end

  assign req_ready = grant;
  assign RegWrite  = regwrite_q;
  assign WriteReg  = writereg_q;
  assign WriteData = writedata_q;
  assign init_busy = (state_q == ST_INIT);

endmodule
